// File: rtl/rsa_modexp_sequencer_pkg.sv
// rsa_modexp_sequencer_pkg: operand select codes, destinations and FSM state encoding for the modexp sequencer
package rsa_modexp_sequencer_pkg;
    localparam logic [2:0] OP_X   = 3'd0;
    localparam logic [2:0] OP_R2  = 3'd1;
    localparam logic [2:0] OP_ONE = 3'd2;
    localparam logic [2:0] OP_ACC = 3'd3;
    localparam logic [2:0] OP_XM  = 3'd4;
    localparam logic DST_ACC = 1'b0;
    localparam logic DST_XM  = 1'b1;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE_X = 3'd1;
    localparam logic [2:0] ST_PRE_A = 3'd2;
    localparam logic [2:0] ST_SQR   = 3'd3;
    localparam logic [2:0] ST_MUL   = 3'd4;
    localparam logic [2:0] ST_POST  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    // wt=0 is the single ISSUE cycle of an op state, wt=1 waits for mont_done
    typedef struct packed {
        logic [2:0] ph;
        logic       wt;
    } seq_state_t;
    function automatic logic is_op(input logic [2:0] ph);
        return ph != ST_IDLE && ph != ST_DONE;
    endfunction
endpackage

// File: rtl/rsa_modexp_sequencer_if.sv
// rsa_modexp_sequencer_if: control handshake between the sequencer and the Montgomery multiplier core
interface rsa_modexp_sequencer_if;
    logic       mont_start;
    logic [2:0] mont_sel_a;
    logic [2:0] mont_sel_b;
    logic       mont_dst;
    logic       mont_done;
    modport master(output mont_start, mont_sel_a, mont_sel_b, mont_dst, input mont_done);
    modport slave(input mont_start, mont_sel_a, mont_sel_b, mont_dst, output mont_done);
endinterface

// File: rtl/rsa_modexp_sequencer_scanner.sv
// rsa_exp_bit_scanner: latched exponent with MSB-first bit down-counter, current bit and last/empty flags
module rsa_exp_bit_scanner #(
    parameter int E_BITS = 1024,
    parameter int LEN_W  = $clog2(E_BITS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [E_BITS-1:0] exp,
    input  logic [LEN_W-1:0]  exp_len,
    output logic              cur_bit,
    output logic              last,
    output logic              empty
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(E_BITS);
    logic [E_BITS-1:0] exp_q;
    logic [E_BITS-1:0] exp_sh;
    logic [LEN_W-1:0]  cnt;
    // cnt holds the number of unprocessed bits, so the current bit index is cnt-1
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            exp_q <= exp;
            cnt   <= exp_len > MAX_LEN ? MAX_LEN : exp_len;
        end else if (step && cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
        end
    end
    assign exp_sh  = exp_q >> (cnt - LEN_W'(1));
    assign cur_bit = exp_sh[0];
    assign last    = cnt == LEN_W'(1);
    assign empty   = cnt == '0;
endmodule

// File: rtl/rsa_modexp_sequencer.sv
// rsa_modexp_sequencer: square-and-multiply control for one Montgomery multiplier.
// Defining RSA_SEQ_PERF_CNT_EN adds the perf_cycles/perf_mults counters.
module rsa_modexp_sequencer
    import rsa_modexp_sequencer_pkg::*;
#(
    parameter int E_BITS = 1024,
    parameter int LEN_W  = $clog2(E_BITS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [E_BITS-1:0] exp,
    input  logic [LEN_W-1:0]  exp_len,
    output logic              busy,
    output logic              done,
`ifdef RSA_SEQ_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_mults,
`endif
    rsa_modexp_sequencer_if.master mont
);
    seq_state_t st, nx;
    logic [2:0] nxt_op;
    logic       accept, adv, step, cur_bit, last, empty;
    assign accept = st.ph == ST_IDLE && start;
    assign adv    = st.wt && mont.mont_done;
    assign step   = adv && (st.ph == ST_MUL || (st.ph == ST_SQR && !cur_bit));
    rsa_exp_bit_scanner #(.E_BITS(E_BITS), .LEN_W(LEN_W)) u_scan (
        .clk(clk), .reset(reset), .load(accept), .step(step),
        .exp(exp), .exp_len(exp_len),
        .cur_bit(cur_bit), .last(last), .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (reset) st <= '{ph: ST_IDLE, wt: 1'b0};
        else st <= nx;
    end
    // SQR with a clear bit and MUL both consume the bit; last consumed bit leads to POST
    always_comb begin
        nxt_op = st.ph == ST_PRE_X ? ST_PRE_A :
                 st.ph == ST_PRE_A ? (empty ? ST_POST : ST_SQR) :
                 st.ph == ST_POST ? ST_DONE :
                 (st.ph == ST_SQR && cur_bit) ? ST_MUL :
                 last ? ST_POST : ST_SQR;
        nx = st;
        case (st.ph)
            ST_IDLE: nx = start ? '{ph: ST_PRE_X, wt: 1'b0} : st;
            ST_DONE: nx = '{ph: ST_IDLE, wt: 1'b0};
            default: nx = !st.wt ? '{ph: st.ph, wt: 1'b1} : adv ? '{ph: nxt_op, wt: 1'b0} : st;
        endcase
    end
    always_comb begin
        busy            = st.ph != ST_IDLE;
        done            = st.ph == ST_DONE;
        mont.mont_start = is_op(st.ph) && !st.wt;
        mont.mont_sel_a = st.ph == ST_PRE_X ? OP_X :
                          st.ph == ST_PRE_A ? OP_ONE :
                          is_op(st.ph) ? OP_ACC : OP_ONE;
        mont.mont_sel_b = (st.ph == ST_PRE_X || st.ph == ST_PRE_A) ? OP_R2 :
                          st.ph == ST_SQR ? OP_ACC :
                          st.ph == ST_MUL ? OP_XM : OP_ONE;
        mont.mont_dst   = st.ph == ST_PRE_X ? DST_XM : DST_ACC;
    end
`ifdef RSA_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            perf_cycles <= '0;
            perf_mults  <= '0;
        end else begin
            if (busy && !done && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
            if (mont.mont_start) perf_mults <= perf_mults + 16'd1;
        end
    end
`endif
endmodule
